// File: rtl/mux_arbiter_2to1.sv
// rtl/mux_arbiter_2to1.sv - two-lane FIFO-buffered arbiter feeding one output channel
// Build option: MUX_ARB_STRICT_PRIORITY_EN (lane 0 always wins contention)
module mux_arbiter_2to1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic             valid_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             valid_in_1,
  output logic             full_0,
  output logic             full_1,
  output logic             overflow_0,
  output logic             overflow_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [1:0]       grant
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE = 2'd0, LAST0 = 2'd1, LAST1 = 2'd2} state_t;
  state_t state;

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      count  [2];
  logic [WIDTH-1:0] din    [2];
  logic [1:0]       vin;
  logic [1:0]       ne;
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       overflow;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign vin    = {valid_in_1, valid_in_0};

  always_comb begin
    ne   = 2'b00;
    full = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ne[i]   = (count[i] != '0);
      full[i] = (count[i] == FULL_CNT);
    end
  end

`ifdef MUX_ARB_STRICT_PRIORITY_EN
  always_comb begin
    pop = 2'b00;
    if (ne[0])      pop = 2'b01;
    else if (ne[1]) pop = 2'b10;
  end
`else
  // Lane served most recently; held across IDLE so fairness survives gaps.
  logic last_rr;

  always_comb begin
    pop = 2'b00;
    if (ne[0] && ne[1]) pop = last_rr ? 2'b01 : 2'b10;
    else if (ne[0])     pop = 2'b01;
    else if (ne[1])     pop = 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_rr <= 1'b1;
    else if (pop[0]) last_rr <= 1'b0;
    else if (pop[1]) last_rr <= 1'b1;
  end
`endif

  // A full lane still accepts a push when it is popped in the same cycle.
  always_comb begin
    push = 2'b00;
    for (int i = 0; i < 2; i++)
      push[i] = vin[i] && (!full[i] || pop[i]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= din[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
        if (vin[i] && !push[i]) overflow[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (pop[0]) begin
      state     <= LAST0;
      data_out  <= mem[0][rd_ptr[0]];
      valid_out <= 1'b1;
    end else if (pop[1]) begin
      state     <= LAST1;
      data_out  <= mem[1][rd_ptr[1]];
      valid_out <= 1'b1;
    end else begin
      state     <= IDLE;
      data_out  <= '0;
      valid_out <= 1'b0;
    end
  end

  // The state register names the lane behind the current data_out word.
  assign grant      = {state == LAST1, state == LAST0};
  assign full_0     = full[0];
  assign full_1     = full[1];
  assign overflow_0 = overflow[0];
  assign overflow_1 = overflow[1];
endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// tb/tb_mux_arbiter_2to1.sv - randomized and directed self-checking bench for mux_arbiter_2to1
module tb_mux_arbiter_2to1;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in_0, data_in_1;
  logic             valid_in_0, valid_in_1;
  logic             full_0, full_1, overflow_0, overflow_1;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [1:0]       grant;

  mux_arbiter_2to1 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1),
    .full_0(full_0), .full_1(full_1),
    .overflow_0(overflow_0), .overflow_1(overflow_1),
    .data_out(data_out), .valid_out(valid_out), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per lane plus the last lane served.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got[$];
  int         last_lane;
  bit         ovf0, ovf1;
  logic [7:0] exp_data;
  bit         exp_valid;
  logic [1:0] exp_grant;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick_lane();
    bit a = (q0.size() > 0);
    bit b = (q1.size() > 0);
    if (a && b) begin
`ifdef MUX_ARB_STRICT_PRIORITY_EN
      return 0;
`else
      return (last_lane == 0) ? 1 : 0;
`endif
    end
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last_lane = 1;
    ovf0 = 0;
    ovf1 = 0;
    exp_data = 8'h00;
    exp_valid = 0;
    exp_grant = 2'b00;
  endtask

  task automatic check_all();
    check_eq("data_out",   data_out,   exp_data);
    check_eq("valid_out",  valid_out,  exp_valid);
    check_eq("grant",      grant,      exp_grant);
    check_eq("full_0",     full_0,     q0.size() == DEPTH);
    check_eq("full_1",     full_1,     q1.size() == DEPTH);
    check_eq("overflow_0", overflow_0, ovf0);
    check_eq("overflow_1", overflow_1, ovf1);
  endtask

  task automatic step(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    int sel;
    @(negedge clk);
    valid_in_0 = v0; data_in_0 = d0;
    valid_in_1 = v1; data_in_1 = d1;
    sel = pick_lane();
    @(posedge clk);
    if (sel == 0) begin
      exp_data = q0.pop_front(); exp_valid = 1; exp_grant = 2'b01; last_lane = 0;
    end else if (sel == 1) begin
      exp_data = q1.pop_front(); exp_valid = 1; exp_grant = 2'b10; last_lane = 1;
    end else begin
      exp_data = 8'h00; exp_valid = 0; exp_grant = 2'b00;
    end
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(d0);
      else ovf0 = 1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(d1);
      else ovf1 = 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    int p;
    bit v0;
    reset = 1'b0;
    valid_in_0 = 0; valid_in_1 = 0;
    data_in_0 = '0; data_in_1 = '0;
    model_reset();
    #12;
    check_eq("rst_data",  data_out,   8'h00);
    check_eq("rst_valid", valid_out,  1'b0);
    check_eq("rst_grant", grant,      2'b00);
    check_eq("rst_full0", full_0,     1'b0);
    check_eq("rst_full1", full_1,     1'b0);
    check_eq("rst_ovf0",  overflow_0, 1'b0);
    check_eq("rst_ovf1",  overflow_1, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Single lane: one-cycle latency, in order, then idle.
    step(1, 8'hA1, 0, 8'h00); check_eq("sl_v_first", valid_out, 1'b0);
    step(1, 8'hA2, 0, 8'h00); check_eq("sl_d1", data_out, 8'hA1); check_eq("sl_g1", grant, 2'b01);
    step(1, 8'hA3, 0, 8'h00); check_eq("sl_d2", data_out, 8'hA2);
    step(0, 8'h00, 0, 8'h00); check_eq("sl_d3", data_out, 8'hA3);
    step(0, 8'h00, 0, 8'h00); check_eq("sl_v_end", valid_out, 1'b0);

    // Asynchronous reset with words queued.
    for (int k = 0; k < 3; k++) step(1, 8'hB0 + k[7:0], 1, 8'hC0 + k[7:0]);
    @(negedge clk);
    valid_in_0 = 0; valid_in_1 = 0;
    #2 reset = 1'b0;
    #1;
    check_eq("arst_data",  data_out,  8'h00);
    check_eq("arst_valid", valid_out, 1'b0);
    check_eq("arst_grant", grant,     2'b00);
    check_eq("arst_full1", full_1,    1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 8'h00);

    // Contention straight after reset: lane 0 first, then strict alternation.
    for (int k = 0; k < 9; k++) begin
      step(k < 4, 8'h10, k < 4, 8'h20);
      if (k >= 1) begin
`ifndef MUX_ARB_STRICT_PRIORITY_EN
        check_eq("cont_d", data_out, ((k - 1) % 2 == 0) ? 8'h10 : 8'h20);
        check_eq("cont_g", grant,    ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
`endif
        check_eq("cont_v", valid_out, 1'b1);
      end
    end

    // Lane 0 held full: pushes only when lane 0 is popped; lane 1 overruns.
    for (int k = 0; k < 16; k++) begin
      v0 = (q0.size() < DEPTH) || (pick_lane() == 0);
      step(v0, 8'h40 + k[7:0], 1, 8'h80 + k[7:0]);
    end
`ifndef MUX_ARB_STRICT_PRIORITY_EN
    check_eq("fp_full0", full_0,     1'b1);
    check_eq("fp_ovf0",  overflow_0, 1'b0);
`endif
    check_eq("fp_ovf1",  overflow_1, 1'b1);
    for (int k = 0; k < 10; k++) step(0, 8'h00, 0, 8'h00);

    // Sparse lane 0 stream wrapping the pointers three times.
    got.delete();
    for (int w = 0; w < 12; w++) begin
      step(1, w[7:0], 0, 8'h00);
      if (valid_out && grant == 2'b01) got.push_back(data_out);
      step(0, 8'h00, 0, 8'h00);
      if (valid_out && grant == 2'b01) got.push_back(data_out);
    end
    step(0, 8'h00, 0, 8'h00);
    check_eq("wrap_n", got.size(), 12);
    for (int i = 0; i < got.size(); i++) check_eq("wrap_d", got[i], i);

    // Random traffic with varying density.
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) p = int'($urandom_range(1, 4));
      step($urandom_range(0, 3) < p, 8'($urandom), $urandom_range(0, 3) < p, 8'($urandom));
    end
    for (int k = 0; k < 10; k++) step(0, 8'h00, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arbiter_2to1.md
# mux_arbiter_2to1

Two-lane buffered arbiter that shares the single 8-bit output channel of the 2:1 mux between lane 0 and lane 1 requesters. Each lane writes words into its own small FIFO under a `valid` strobe. A round-robin scheduler pops at most one word per cycle onto `data_out`/`valid_out` and tags it with a one-hot `grant`. The block sits directly in front of the mux output channel and replaces free-running lane selection with fair, lossless sequencing, including back-pressure.

## Interface
Parameters:
- `WIDTH`, 8, data word width.
- `DEPTH`, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in_0`  in  WIDTH  lane 0 write data.
- `valid_in_0`  in  1  lane 0 push strobe.
- `data_in_1`  in  WIDTH  lane 1 write data.
- `valid_in_1`  in  1  lane 1 push strobe.
- `full_0`, `full_1`  out  1  lane FIFO count equals DEPTH (combinational from count).
- `overflow_0`, `overflow_1`  out  1  sticky: a lane push was dropped.
- `data_out`  out  WIDTH  arbitrated word, registered.
- `valid_out`  out  1  `data_out` holds a word this cycle, registered.
- `grant`  out  2  one-hot source lane of the current `data_out`; 2'b00 when idle.

## Operation
- Each lane has a FIFO with wrapping read/write pointers of width log2(DEPTH) and a count of width log2(DEPTH)+1.
- Push is accepted when `valid_in_x` is high and the FIFO is not full, or when it is full and the same lane is popped in the same cycle.
- A push onto a full FIFO with no pop is dropped, sets `overflow_x`, and leaves the FIFO unchanged. `overflow_x` clears only on reset.
- Scheduler FSM, `state` = last lane served:
  - IDLE: neither FIFO non-empty last cycle.
  - LAST0: lane 0 was served last cycle.
  - LAST1: lane 1 was served last cycle.
- Each cycle, the pop decision uses the pre-edge counts:
  - Both lanes non-empty: pop the lane not served last. From IDLE or after reset, lane 0 wins first. A `last_rr` register keeps the round-robin pointer across IDLE.
  - Exactly one lane non-empty: pop that lane; go to LAST0 or LAST1 accordingly.
  - Neither non-empty: go to IDLE; `valid_out` = 0, `data_out` = 0, `grant` = 0.
- A popped word is registered into `data_out` together with `valid_out` = 1 and the matching `grant` bit.
- No output back-pressure: the consumer must accept one word per cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - All pointers and counts are 0.
  - `state` = IDLE, `last_rr` = lane 1, so lane 0 wins first.
  - `data_out` = 0, `valid_out` = 0, `grant` = 0.
  - `full_x` = 0, `overflow_x` = 0.
- Latency: a word pushed at edge n (lane empty, no contention) appears on `data_out` after edge n+1.
- A push into an empty FIFO is not poppable in the same cycle; there is no bypass.
- Throughput: 1 word/cycle aggregate. Under sustained contention each lane gets exactly every other cycle.
- Full boundary: with count = DEPTH, push plus pop in the same cycle keeps count = DEPTH and does not set overflow.
- Pointer wrap from DEPTH-1 to 0 is seamless; ordering within a lane is strictly FIFO.
- Reset asserted mid-burst: all buffered words are discarded and outputs go to their reset values immediately (asynchronously).

## Configuration
- Macro `MUX_ARB_STRICT_PRIORITY_EN`:
  - Defined: lane 0 always wins when both lanes are non-empty. Lane 1 is served only when lane 0 is empty. `last_rr` is unused. The LAST0, LAST1 and IDLE states are still tracked for `grant`.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Reset: assert `reset` = 0 mid-stream with 3 words queued on lane 0 -> outputs 0 immediately. After release, `valid_out` stays 0 until a new push.
- Single lane: push 8'hA1, 8'hA2, 8'hA3 on lane 0 on consecutive cycles -> `data_out` A1, A2, A3 on cycles 2 to 4, `grant` = 2'b01, then `valid_out` = 0.
- Contention: push 8'h10/8'h20 on lanes 0/1 on the same cycles for 4 cycles -> output sequence 10, 20, 10, 20, ... with alternating `grant` 01/10.
- Overflow: push 5 words on lane 1 in one cycle each while lane 0 holds the arbiter, `MUX_ARB_STRICT_PRIORITY_EN` defined, DEPTH = 4 -> `full_1` = 1 after the 4th push. The 5th word is dropped, `overflow_1` = 1, and exactly 4 words exit in order.
- Full with simultaneous pop: lane 0 full and being popped while a push arrives -> word accepted, `overflow_0` stays 0, count stays 4.
- Wrap: 12 sequential lane 0 words 8'h00 to 8'h0B with sparse pushes -> all exit in order across 3 pointer wraps.
